lcd_message_sequencer: RTL and testbench

Command sequencer that sits between the application logic and `LCD_executor`. It holds a 32-character, two-line message buffer and, on `START`, issues the executor command stream to draw the message: clear, line-1 address, 16 writes, line-2 address, 16 writes. It can optionally repeat the refresh every 2 s. It owns the executor's `ENB`, `RST`, `OP` and `DATA` inputs and consumes its `RDY` output.

---
 rtl/lcd_message_sequencer.sv | 104 ++++++++++
 tb/tb_lcd_message_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_message_sequencer.sv
// lcd_message_sequencer: draws a 32-char two-line buffer through LCD_executor, optionally every 2 s
module lcd_message_sequencer #(
  parameter logic [7:0] LINE1_ADDR = 8'h00,
  parameter logic [7:0] LINE2_ADDR = 8'h40,
  parameter logic [7:0] FILL_CHAR  = 8'h20
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       WR_EN,
  input  logic [4:0] WR_ADDR,
  input  logic [7:0] WR_DATA,
  input  logic       START,
  input  logic       STOP,
  input  logic       REPEAT,
  input  logic       EXE_RDY,
  output logic       EXE_ENB,
  output logic       EXE_RSTN,
  output logic [3:0] EXE_OP,
  output logic [7:0] EXE_DATA,
  output logic       BUSY,
  output logic       DONE
);
  typedef enum logic [2:0] {IDLE, CLR, ADDR1, LINE1, ADDR2, LINE2, WAIT2S} state_t;
  state_t     state;
  logic [3:0] idx;
  logic       rep;
  logic [7:0] mem [32];
  // Same-cycle writes are forwarded so the next character loaded is never stale.
  function automatic logic [7:0] rd(input logic [4:0] a);
    return (WR_EN && WR_ADDR == a) ? WR_DATA : mem[a];
  endfunction
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      idx      <= '0;
      rep      <= 1'b0;
      EXE_ENB  <= 1'b0;
      EXE_RSTN <= 1'b0;
      EXE_OP   <= 4'hF;
      EXE_DATA <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      for (int i = 0; i < 32; i++) mem[i] <= FILL_CHAR;
    end else begin
      EXE_ENB  <= 1'b1;
      EXE_RSTN <= 1'b1;
      DONE     <= 1'b0;
      if (WR_EN) mem[WR_ADDR] <= WR_DATA;
      if (STOP) begin
        state    <= IDLE;
        EXE_OP   <= 4'hF;
        EXE_DATA <= '0;
        BUSY     <= 1'b0;
      end else if (state == IDLE) begin
        if (START) begin
          state    <= CLR;
          rep      <= REPEAT;
          BUSY     <= 1'b1;
          EXE_OP   <= 4'h0;
          EXE_DATA <= '0;
        end
      end else if (EXE_RDY) begin
        case (state)
          CLR, WAIT2S: begin
            state    <= ADDR1;
            EXE_OP   <= 4'h3;
            EXE_DATA <= LINE1_ADDR;
          end
          ADDR1: begin
            state    <= LINE1;
            idx      <= '0;
            EXE_OP   <= 4'h1;
            EXE_DATA <= rd(5'd0);
          end
          LINE1: begin
            idx      <= idx + 4'd1;
            state    <= (idx == 4'd15) ? ADDR2 : LINE1;
            EXE_OP   <= (idx == 4'd15) ? 4'h3 : 4'h1;
            EXE_DATA <= (idx == 4'd15) ? LINE2_ADDR : rd({1'b0, idx + 4'd1});
          end
          ADDR2: begin
            state    <= LINE2;
            idx      <= '0;
            EXE_OP   <= 4'h1;
            EXE_DATA <= rd(5'd16);
          end
          LINE2: begin
            idx <= idx + 4'd1;
            if (idx == 4'd15) begin
              DONE     <= 1'b1;
              state    <= rep ? WAIT2S : IDLE;
              EXE_OP   <= rep ? 4'h4 : 4'hF;
              EXE_DATA <= '0;
              BUSY     <= rep;
            end else begin
              EXE_DATA <= rd({1'b1, idx + 4'd1});
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_lcd_message_sequencer.sv
// tb_lcd_message_sequencer: scoreboard bench; stimulus queues expected commands, monitor checks accepts
module tb_lcd_message_sequencer;
  logic       CLK = 0, RST = 1, WR_EN = 0, START = 0, STOP = 0, REPEAT = 0, EXE_RDY = 0;
  logic [4:0] WR_ADDR = '0;
  logic [7:0] WR_DATA = '0;
  logic       EXE_ENB, EXE_RSTN, BUSY, DONE;
  logic [3:0] EXE_OP;
  logic [7:0] EXE_DATA;
  int         checks = 0, failures = 0, n_acc = 0, done_cnt = 0, cnt = 0;
  bit         rdy_en = 1;
  logic [11:0] q[$];
  logic [7:0]  mb[32];

  lcd_message_sequencer dut (
    .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .START(START), .STOP(STOP), .REPEAT(REPEAT), .EXE_RDY(EXE_RDY),
    .EXE_ENB(EXE_ENB), .EXE_RSTN(EXE_RSTN), .EXE_OP(EXE_OP), .EXE_DATA(EXE_DATA),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Executor model: one-cycle RDY pulse every 10 cycles
  always @(posedge CLK) begin
    #1;
    cnt = (cnt == 9) ? 0 : cnt + 1;
    EXE_RDY = rdy_en && cnt == 0;
  end

  // Monitor: a command presented with RDY high is consumed at the coming edge
  always @(negedge CLK) begin
    if (DONE) done_cnt++;
    if (!RST && EXE_RDY && EXE_OP != 4'hF) begin
      n_acc++;
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_cmd #%0d: got %0h expected none", n_acc, {EXE_OP, EXE_DATA});
      end else begin
        chk($sformatf("cmd#%0d", n_acc), {20'd0, EXE_OP, EXE_DATA}, {20'd0, q.pop_front()});
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic wr_dut(input logic [4:0] a, input logic [7:0] d);
    WR_EN = 1; WR_ADDR = a; WR_DATA = d;
    tick();
    WR_EN = 0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    wr_dut(a, d);
    mb[a] = d;
  endtask

  task automatic push_pass(input bit clr);
    if (clr) q.push_back(12'h000);
    q.push_back(12'h300);
    for (int i = 0; i < 16; i++) q.push_back({4'h1, mb[i]});
    q.push_back(12'h340);
    for (int i = 16; i < 32; i++) q.push_back({4'h1, mb[i]});
  endtask

  task automatic pulse_start(input bit rep);
    START = 1; REPEAT = rep;
    tick();
    START = 0; REPEAT = 0;
  endtask

  task automatic wait_acc(input int n, input string nm);
    int t = 0;
    while (n_acc < n && t < 2000) begin tick(); t++; end
    if (n_acc < n) begin
      checks++; failures++;
      $display("FAIL %s timeout: got %0d accepts expected %0d", nm, n_acc, n);
    end
  endtask

  task automatic wait_done(input string nm);
    int t = 0;
    while (!DONE && t < 2000) begin tick(); t++; end
    if (!DONE) begin
      checks++; failures++;
      $display("FAIL %s timeout: got no DONE expected DONE", nm);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] hello [5];
    logic [7:0] world [5];
    int base;
    hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
    world = '{8'h57, 8'h4F, 8'h52, 8'h4C, 8'h44};
    for (int i = 0; i < 32; i++) mb[i] = 8'h20;
    // 1: reset and idle
    tick(3);
    chk("rst_op", EXE_OP, 4'hF);
    chk("rst_rstn", EXE_RSTN, 0);
    chk("rst_enb", EXE_ENB, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    RST = 0;
    tick();
    chk("post_rst_enb", EXE_ENB, 1);
    chk("post_rst_rstn", EXE_RSTN, 1);
    chk("post_rst_op", EXE_OP, 4'hF);
    tick(30);
    chk("idle_no_cmd", n_acc, 0);
    chk("idle_busy", BUSY, 0);
    // 2: one-shot pass
    for (int i = 0; i < 5; i++) wr(5'(i), hello[i]);
    for (int i = 0; i < 5; i++) wr(5'(16 + i), world[i]);
    push_pass(1);
    pulse_start(0);
    chk("start_op", EXE_OP, 4'h0);
    chk("start_busy", BUSY, 1);
    wait_done("oneshot_done");
    chk("oneshot_busy_fall", BUSY, 0);
    chk("oneshot_op_idle", EXE_OP, 4'hF);
    tick();
    chk("oneshot_q_empty", q.size(), 0);
    chk("oneshot_done_cnt", done_cnt, 1);
    // 3: repeat mode
    push_pass(1);
    q.push_back(12'h400);
    push_pass(0);
    pulse_start(1);
    wait_done("rep_done1");
    chk("rep_op4_1", EXE_OP, 4'h4);
    chk("rep_busy_1", BUSY, 1);
    tick();
    wait_done("rep_done2");
    chk("rep_op4_2", EXE_OP, 4'h4);
    rdy_en = 0;
    STOP = 1;
    tick();
    STOP = 0;
    chk("stop_op", EXE_OP, 4'hF);
    chk("stop_busy", BUSY, 0);
    chk("rep_q_empty", q.size(), 0);
    chk("rep_done_cnt", done_cnt, 3);
    rdy_en = 1;
    // 4: live buffer update during LINE1 idx 3
    mb[10] = 8'h41;
    push_pass(1);
    pulse_start(0);
    base = n_acc;
    wait_acc(base + 5, "live_wait");
    wr_dut(5'd10, 8'h41);
    wr_dut(5'd2, 8'h42);
    mb[2] = 8'h42;
    wait_done("live_done");
    chk("live_busy", BUSY, 0);
    tick();
    chk("live_q_empty", q.size(), 0);
    // 5: START+STOP together, START mid-pass
    START = 1; STOP = 1;
    tick();
    START = 0; STOP = 0;
    chk("startstop_busy", BUSY, 0);
    chk("startstop_op", EXE_OP, 4'hF);
    base = n_acc;
    tick(25);
    chk("startstop_no_cmd", n_acc, base);
    push_pass(1);
    pulse_start(0);
    wait_acc(base + 10, "mid_wait");
    pulse_start(1);
    wait_done("mid_done");
    chk("mid_busy", BUSY, 0);
    chk("mid_op", EXE_OP, 4'hF);
    tick();
    chk("mid_q_empty", q.size(), 0);
    // 6: reset at LINE2 idx 7
    push_pass(1);
    pulse_start(0);
    base = n_acc;
    wait_acc(base + 26, "rst_mid_wait");
    chk("rst_mid_line2_7", {EXE_OP, EXE_DATA}, {4'h1, mb[23]});
    RST = 1;
    tick();
    chk("rst_mid_rstn", EXE_RSTN, 0);
    chk("rst_mid_op", EXE_OP, 4'hF);
    chk("rst_mid_busy", BUSY, 0);
    q.delete();
    RST = 0;
    tick();
    chk("rst_mid_rstn_up", EXE_RSTN, 1);
    for (int i = 0; i < 32; i++) mb[i] = 8'h20;
    push_pass(1);
    pulse_start(0);
    wait_done("refill_done");
    tick();
    chk("refill_q_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
